// File: rtl/pim_pkg.sv
// Shared types and pin-encoding constants for the PIM bus-to-pin bridge.
package pim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } pim_state_e;

    localparam int unsigned PIM_STB_BIT = 31;
    localparam int unsigned PIM_WE_BIT  = 30;
    localparam int unsigned PIM_WADDR_W = 30;

    // Word address with strobe and write-enable folded into the top bits.
    function automatic logic [31:0] pim_addr_word(input logic                   we,
                                                  input logic [PIM_WADDR_W-1:0] waddr);
        logic [31:0] word;
        word                    = '0;
        word[PIM_STB_BIT]       = 1'b1;
        word[PIM_WE_BIT]        = we;
        word[PIM_WADDR_W-1:0]   = waddr;
        return word;
    endfunction

endpackage

// File: rtl/pim_bridge_if.sv
// Core request/response port, PIM pin bus and perf counters of the PIM bridge.
interface pim_bridge_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] resp_rdata_o;
    logic            busy_o;
    logic [XLEN-1:0] pim_addr_o;
    logic [XLEN-1:0] pim_wr_o;
    logic [XLEN-1:0] pim_rd_i;
    logic [31:0]     rd_cnt_o;
    logic [31:0]     wr_cnt_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i, pim_rd_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, busy_o, pim_addr_o, pim_wr_o,
               rd_cnt_o, wr_cnt_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i, pim_rd_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, busy_o, pim_addr_o, pim_wr_o,
               rd_cnt_o, wr_cnt_o
    );
endinterface

// File: rtl/pim_perf_counter.sv
// Wrap-around event counter used for the bridge's read/write completion counts.
module pim_perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i) begin
            cnt_o <= cnt_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pim_bridge.sv
// Bridge from one load/store handshake to a timed PIM pin transaction.
// Optional completion counters are built only when PIM_PERF_CNT_EN is defined.
module pim_bridge
    import pim_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    pim_bridge_if.slave  bus
);

    localparam int unsigned MAX_N = (RD_LATENCY > HOLD_CYCLES) ? RD_LATENCY : HOLD_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_N) + 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(HOLD_CYCLES - 1);

    pim_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic            we_q, we_nxt;
    logic [XLEN-1:0] pim_addr_q, pim_addr_nxt;
    logic [XLEN-1:0] pim_wr_q, pim_wr_nxt;
    logic            resp_valid_q, resp_valid_nxt;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_nxt;
    logic            busy_q;

    // Byte-lane bits never reach the word-addressed pins.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            pim_addr_q   <= '0;
            pim_wr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt_q        <= cnt_nxt;
            we_q         <= we_nxt;
            pim_addr_q   <= pim_addr_nxt;
            pim_wr_q     <= pim_wr_nxt;
            resp_valid_q <= resp_valid_nxt;
            resp_rdata_q <= resp_rdata_nxt;
            busy_q       <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt_q;
        we_nxt         = we_q;
        pim_addr_nxt   = pim_addr_q;
        pim_wr_nxt     = pim_wr_q;
        resp_valid_nxt = resp_valid_q;
        resp_rdata_nxt = resp_rdata_q;

        unique case (state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    state_nxt    = ISSUE;
                    we_nxt       = bus.req_we_i;
                    cnt_nxt      = bus.req_we_i ? WR_LOAD : RD_LOAD;
                    pim_addr_nxt = XLEN'(pim_addr_word(bus.req_we_i,
                                                       bus.req_addr_i[PIM_WADDR_W+1:2]));
                    pim_wr_nxt   = bus.req_we_i ? bus.req_wdata_i : '0;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    // Final pin cycle: capture read data and release pins on the same edge.
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = we_q ? '0 : bus.pim_rd_i;
                    pim_addr_nxt   = '0;
                    pim_wr_nxt     = '0;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    state_nxt      = IDLE;
                    resp_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready_o  = (state == IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.busy_o       = busy_q;
    assign bus.pim_addr_o   = pim_addr_q;
    assign bus.pim_wr_o     = pim_wr_q;

`ifdef PIM_PERF_CNT_EN
    logic rd_done, wr_done;
    assign rd_done = (state == RESP) && bus.resp_ready_i && !we_q;
    assign wr_done = (state == RESP) && bus.resp_ready_i &&  we_q;

    pim_perf_counter #(.WIDTH(32)) u_rd_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (rd_done),
        .cnt_o  (bus.rd_cnt_o)
    );

    pim_perf_counter #(.WIDTH(32)) u_wr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (wr_done),
        .cnt_o  (bus.wr_cnt_o)
    );
`else
    assign bus.rd_cnt_o = '0;
    assign bus.wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pim_bridge.sv
// Self-checking bench for pim_bridge: transaction-level reference model plus directed literals.
module tb_pim_bridge;
    import pim_pkg::*;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned HOLD   = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    pim_bridge_if #(.XLEN(32)) b ();

    pim_bridge #(
        .XLEN        (32),
        .RD_LATENCY  (RD_LAT),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding transaction, age counted in cycles since acceptance.
    logic        m_out     = 1'b0;
    int          m_age     = 0;
    int          m_n       = 0;
    logic        m_we      = 1'b0;
    logic [31:0] m_addr    = '0;
    logic [31:0] m_wdata   = '0;
    logic [31:0] m_rdata   = '0;
    logic [31:0] m_rd_hs   = '0;
    logic [31:0] m_wr_hs   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= 1'b0;
            m_age   <= 0;
            m_rd_hs <= '0;
            m_wr_hs <= '0;
        end else if (m_out) begin
            if (m_age > m_n) begin
                if (b.resp_ready_i) begin
                    m_out <= 1'b0;
                    if (m_we) m_wr_hs <= m_wr_hs + 1;
                    else      m_rd_hs <= m_rd_hs + 1;
                end
            end else begin
                if (m_age == m_n) m_rdata <= m_we ? 32'h0 : b.pim_rd_i;
                m_age <= m_age + 1;
            end
        end else if (b.req_valid_i) begin
            m_out   <= 1'b1;
            m_age   <= 1;
            m_we    <= b.req_we_i;
            m_addr  <= b.req_addr_i;
            m_wdata <= b.req_wdata_i;
            m_n     <= b.req_we_i ? int'(HOLD) : int'(RD_LAT);
        end
    end

    // Per-cycle compare against the model, mid-way through the low phase.
    always @(negedge clk) begin
        logic        pins, rv;
        logic [31:0] exp_addr, exp_wr, exp_rc, exp_wc;
        #2;
        pins     = m_out && (m_age <= m_n);
        rv       = m_out && (m_age > m_n);
        exp_addr = pins ? (32'h8000_0000 | (m_we ? 32'h4000_0000 : 32'h0) | (m_addr >> 2)) : 32'h0;
        exp_wr   = (pins && m_we) ? m_wdata : 32'h0;
`ifdef PIM_PERF_CNT_EN
        exp_rc = m_rd_hs;
        exp_wc = m_wr_hs;
`else
        exp_rc = 32'h0;
        exp_wc = 32'h0;
`endif
        chk("req_ready",  {31'b0, b.req_ready_o},  {31'b0, !m_out});
        chk("busy",       {31'b0, b.busy_o},       {31'b0, m_out});
        chk("resp_valid", {31'b0, b.resp_valid_o}, {31'b0, rv});
        chk("pim_addr",   b.pim_addr_o, exp_addr);
        chk("pim_wr",     b.pim_wr_o,   exp_wr);
        if (rv) chk("resp_rdata", b.resp_rdata_o, m_rdata);
        chk("rd_cnt", b.rd_cnt_o, exp_rc);
        chk("wr_cnt", b.wr_cnt_o, exp_wc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        b.req_valid_i = v;
        b.req_we_i    = we;
        b.req_addr_i  = a;
        b.req_wdata_i = d;
    endtask

    logic        bb_we[3];
    logic [31:0] bb_addr[3];
    int          acc[3];
    int          idx;
    int          waited;
    logic [31:0] exp_rd2, exp_wr1;

    initial begin
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        b.resp_ready_i = 1'b0;
        b.pim_rd_i     = 32'h0;

        repeat (3) step();
        chk("rst_ready",      {31'b0, b.req_ready_o},  32'h1);
        chk("rst_resp_valid", {31'b0, b.resp_valid_o}, 32'h0);
        chk("rst_pim_addr",   b.pim_addr_o, 32'h0);
        chk("rst_rdata",      b.resp_rdata_o, 32'h0);
        chk("rst_busy",       {31'b0, b.busy_o}, 32'h0);
        rst_n = 1'b1;

        // Single write
        step();
        drive_req(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        b.resp_ready_i = 1'b1;
        step();
        b.req_valid_i = 1'b0;
        chk("wr_pim_addr_c1", b.pim_addr_o, 32'hC000_0004);
        chk("wr_pim_wr_c1",   b.pim_wr_o,   32'hDEAD_BEEF);
        step();
        chk("wr_pim_addr_c2", b.pim_addr_o, 32'h0);
        chk("wr_resp_valid",  {31'b0, b.resp_valid_o}, 32'h1);
        chk("wr_resp_rdata",  b.resp_rdata_o, 32'h0);
        step();
        chk("wr_ready_after", {31'b0, b.req_ready_o}, 32'h1);

        // Single read
        drive_req(1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_0000);
        step();
        b.req_valid_i = 1'b0;
        chk("rd_pim_addr_c1", b.pim_addr_o, 32'h8000_0040);
        chk("rd_pim_wr_c1",   b.pim_wr_o,   32'h0);
        step();
        b.pim_rd_i = 32'h1234_5678;
        chk("rd_pim_addr_c2", b.pim_addr_o, 32'h8000_0040);
        step();
        b.pim_rd_i = 32'h0;
        chk("rd_resp_valid", {31'b0, b.resp_valid_o}, 32'h1);
        chk("rd_resp_rdata", b.resp_rdata_o, 32'h1234_5678);
        step();

        // Backpressure with a second request waiting
        drive_req(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        b.resp_ready_i = 1'b0;
        step();
        drive_req(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0055);
        step();
        b.pim_rd_i = 32'hA5A5_0F0F;
        step();
        b.pim_rd_i = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_valid", {31'b0, b.resp_valid_o}, 32'h1);
            chk("bp_resp_rdata", b.resp_rdata_o, 32'hA5A5_0F0F);
            chk("bp_req_ready",  {31'b0, b.req_ready_o}, 32'h0);
            step();
        end
        chk("bp_still_held", b.resp_rdata_o, 32'hA5A5_0F0F);
        b.resp_ready_i = 1'b1;
        step();
        chk("bp_ready_after_hs", {31'b0, b.req_ready_o}, 32'h1);
        step();
        b.req_valid_i = 1'b0;
        chk("bp_second_addr", b.pim_addr_o, 32'hC000_0010);
        chk("bp_second_wr",   b.pim_wr_o,   32'h0000_0055);
        repeat (3) step();

        // Reset in the first pin cycle of a read
        drive_req(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        step();
        b.req_valid_i = 1'b0;
        chk("rr_pim_addr_c1", b.pim_addr_o, 32'h8000_00C0);
        rst_n = 1'b0;
        #1;
        chk("rr_pim_addr",   b.pim_addr_o, 32'h0);
        chk("rr_resp_valid", {31'b0, b.resp_valid_o}, 32'h0);
        chk("rr_ready",      {31'b0, b.req_ready_o}, 32'h1);
        chk("rr_busy",       {31'b0, b.busy_o}, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_no_resp", {31'b0, b.resp_valid_o}, 32'h0);
        end

        // Back-to-back read, write, read with resp_ready high
        bb_we[0] = 1'b0; bb_addr[0] = 32'h0000_0400;
        bb_we[1] = 1'b1; bb_addr[1] = 32'h0000_0404;
        bb_we[2] = 1'b0; bb_addr[2] = 32'h0000_0408;
        b.resp_ready_i = 1'b1;
        idx = 0;
        drive_req(1'b1, bb_we[0], bb_addr[0], 32'h1111_0000);
        for (int t = 0; t < 40 && idx < 3; t++) begin
            if (b.req_ready_o) begin
                acc[idx] = cyc;
                idx++;
            end
            step();
            b.pim_rd_i = $urandom;
            if (idx < 3) drive_req(1'b1, bb_we[idx], bb_addr[idx], 32'h1111_0000 + idx);
            else         b.req_valid_i = 1'b0;
        end
        chk("b2b_accepted", idx, 3);
        if (idx == 3) begin
            chk("b2b_gap_rd_wr", acc[1] - acc[0], 4);
            chk("b2b_gap_wr_rd", acc[2] - acc[1], 3);
            waited = 0;
            while (!b.req_ready_o && waited < 20) begin
                step();
                waited++;
            end
            chk("b2b_gap_rd_next", cyc - acc[2], 4);
`ifdef PIM_PERF_CNT_EN
            exp_rd2 = 32'd2;
            exp_wr1 = 32'd1;
`else
            exp_rd2 = 32'd0;
            exp_wr1 = 32'd0;
`endif
            chk("b2b_rd_cnt", b.rd_cnt_o, exp_rd2);
            chk("b2b_wr_cnt", b.wr_cnt_o, exp_wr1);
        end

        // Randomised traffic with backpressure and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n = ($urandom_range(0, 399) != 0);
            drive_req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom);
            b.resp_ready_i = ($urandom_range(0, 9) < 7);
            b.pim_rd_i     = $urandom;
        end
        rst_n = 1'b1;
        b.req_valid_i  = 1'b0;
        b.resp_ready_i = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
